// File: rtl/mmio_request_sequencer_if.sv
// Host command/response channel plus MMIO read/write channels
// toward the memory mapper, bundled for the request sequencer.
interface mmio_request_sequencer_if #(
  parameter int INDEX_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [INDEX_WIDTH-1:0] cmd_index;
  logic [DATA_WIDTH-1:0]  cmd_data;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic                   rsp_error;

  logic                   read_req;
  logic [INDEX_WIDTH-1:0] read_index;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   read_ack;

  logic                   write_req;
  logic [INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   write_ack;

  logic [15:0]            timeout_count;

  modport slave (
    input  cmd_valid, cmd_write, cmd_index, cmd_data,
    input  rsp_ready, read_data, read_ack, write_ack,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output read_req, read_index,
    output write_req, write_index, write_data,
    output timeout_count
  );

  modport master (
    output cmd_valid, cmd_write, cmd_index, cmd_data,
    output rsp_ready, read_data, read_ack, write_ack,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  read_req, read_index,
    input  write_req, write_index, write_data,
    input  timeout_count
  );
endinterface

// File: rtl/mmio_request_sequencer.sv
// Single-outstanding MMIO engine: holds a request until ack or
// timeout, then returns data/status over the response channel.
module mmio_request_sequencer #(
  parameter int INDEX_WIDTH    = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA =
    DATA_WIDTH'(32'hDEADBEEF)
) (
  input logic clock,
  input logic reset,
  mmio_request_sequencer_if.slave bus
);

  localparam int I_IDLE  = 0;
  localparam int I_READ  = 1;
  localparam int I_WRITE = 2;
  localparam int I_RSP   = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_READ  = 4'b0010,
    S_WRITE = 4'b0100,
    S_RSP   = 4'b1000
  } state_t;

  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(LAST);

  state_t state_q, state_d;

  logic [INDEX_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0]  dat_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]  rsp_data_q;
  logic                   rsp_err_q;
  logic [15:0]            tc_q;

  logic in_req;
  logic ack;
  logic to_hit;

  // One-hot state: each req output is a single flop bit.
  assign in_req = state_q[I_READ] | state_q[I_WRITE];
  assign ack = state_q[I_READ]  ? bus.read_ack :
               state_q[I_WRITE] ? bus.write_ack : 1'b0;
  assign to_hit = TO_EN && in_req && !ack &&
                  (cnt_q == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[I_IDLE]:
        if (bus.cmd_valid)
          state_d = bus.cmd_write ? S_WRITE : S_READ;
      state_q[I_READ]:
        if (bus.read_ack || to_hit) state_d = S_RSP;
      state_q[I_WRITE]:
        if (bus.write_ack || to_hit) state_d = S_RSP;
      state_q[I_RSP]:
        if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = state_q[I_IDLE];
    bus.rsp_valid   = state_q[I_RSP];
    bus.read_req    = state_q[I_READ];
    bus.read_index  = state_q[I_READ] ? idx_q : '0;
    bus.write_req   = state_q[I_WRITE];
    bus.write_index = state_q[I_WRITE] ? idx_q : '0;
    bus.write_data  = state_q[I_WRITE] ? dat_q : '0;
  end

  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_error     = rsp_err_q;
  assign bus.timeout_count = tc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q      <= '0;
      dat_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tc_q       <= '0;
    end else begin
      if (state_q[I_IDLE] && bus.cmd_valid) begin
        idx_q <= bus.cmd_index;
        dat_q <= bus.cmd_data;
        cnt_q <= '0;
      end else if (in_req) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Ack takes priority over a timeout on the same edge.
      if (state_q[I_READ] && bus.read_ack) begin
        rsp_data_q <= bus.read_data;
        rsp_err_q  <= 1'b0;
      end else if (state_q[I_WRITE] && bus.write_ack) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end else if (to_hit) begin
        rsp_data_q <= state_q[I_READ] ? ERROR_DATA : '0;
        rsp_err_q  <= 1'b1;
        if (tc_q != 16'hFFFF) tc_q <= tc_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_request_sequencer.sv
// Directed and randomized checks of the MMIO request sequencer
// against a transaction-level expectation model.
module tb_mmio_request_sequencer;

  localparam int T = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int tests = 0;
  int fails = 0;
  int tc_model = 0;

  mmio_request_sequencer_if #(
    .INDEX_WIDTH(32),
    .DATA_WIDTH (32)
  ) bus ();

  mmio_request_sequencer #(
    .INDEX_WIDTH   (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(T),
    .ERROR_DATA    (32'hDEADBEEF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.read_data = '0;
    bus.read_ack  = 1'b0;
    bus.write_ack = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_read_req"}, 64'(bus.read_req), 64'(0));
    check({tag, "_write_req"}, 64'(bus.write_req), 64'(0));
    check({tag, "_read_index"}, 64'(bus.read_index), 64'(0));
    check({tag, "_write_index"}, 64'(bus.write_index), 64'(0));
    check({tag, "_write_data"}, 64'(bus.write_data), 64'(0));
  endtask

  // ack_at: req cycle (0-based) in which the device acks, <0 = never.
  task automatic txn(input bit wr,
                     input logic [31:0] idx,
                     input logic [31:0] dat,
                     input logic [31:0] rdat,
                     input int ack_at,
                     input int bp);
    bit timed;
    int len;
    logic [31:0] exp_d;
    timed = (ack_at < 0) || (ack_at >= T);
    len   = timed ? T : ack_at + 1;
    exp_d = wr ? 32'h0 : (timed ? 32'hDEADBEEF : rdat);
    if (timed && tc_model < 16'hFFFF) tc_model++;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_index = idx;
    bus.cmd_data  = dat;
    bus.rsp_ready = 1'b0;
    check("accept_ready", 64'(bus.cmd_ready), 64'(1));
    tick;
    bus.cmd_valid = 1'b0;
    bus.cmd_index = $urandom;
    bus.cmd_data  = $urandom;

    for (int k = 0; k < len; k++) begin
      check("req_rd", 64'(bus.read_req), 64'(!wr));
      check("req_wr", 64'(bus.write_req), 64'(wr));
      check("req_rd_idx", 64'(bus.read_index),
            64'(wr ? 32'h0 : idx));
      check("req_wr_idx", 64'(bus.write_index),
            64'(wr ? idx : 32'h0));
      check("req_wr_data", 64'(bus.write_data),
            64'(wr ? dat : 32'h0));
      check("req_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("req_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      if (wr) begin
        bus.write_ack = (k == ack_at);
        bus.read_ack  = 1'($urandom_range(0, 1));
      end else begin
        bus.read_ack  = (k == ack_at);
        bus.write_ack = 1'($urandom_range(0, 1));
      end
      bus.read_data = (k == ack_at) ? rdat : $urandom;
      tick;
    end
    bus.read_ack  = 1'b0;
    bus.write_ack = 1'b0;

    check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("rsp_data", 64'(bus.rsp_data), 64'(exp_d));
    check("rsp_error", 64'(bus.rsp_error), 64'(timed));
    check("rsp_tcount", 64'(bus.timeout_count), 64'(tc_model));
    check("rsp_rd_req", 64'(bus.read_req), 64'(0));
    check("rsp_wr_req", 64'(bus.write_req), 64'(0));
    check("rsp_cmd_ready", 64'(bus.cmd_ready), 64'(0));

    bus.cmd_valid = (bp > 0);
    bus.cmd_write = 1'($urandom_range(0, 1));
    for (int b = 0; b < bp; b++) begin
      tick;
      check("bp_valid", 64'(bus.rsp_valid), 64'(1));
      check("bp_data", 64'(bus.rsp_data), 64'(exp_d));
      check("bp_error", 64'(bus.rsp_error), 64'(timed));
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      check("bp_rd_req", 64'(bus.read_req), 64'(0));
      check("bp_wr_req", 64'(bus.write_req), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("back_idle_ready", 64'(bus.cmd_ready), 64'(1));
    check("back_idle_valid", 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    quiet_inputs();
    reset = 1'b1;
    tick;
    tick;
    check_idle_outs("reset");
    check("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
    check("reset_rsp_error", 64'(bus.rsp_error), 64'(0));
    check("reset_tcount", 64'(bus.timeout_count), 64'(0));
    reset = 1'b0;
    tick;
    check_idle_outs("post_reset");

    txn(1'b0, 32'h40000003, 32'h0, 32'h12345678, 0, 0);
    txn(1'b1, 32'h00001234, 32'hA5A5A5A5, 32'h0, 4, 0);
    txn(1'b0, 32'h7FFFFFF0, 32'h0, 32'h0, -1, 0);
    txn(1'b0, 32'h00000010, 32'h0, 32'hCAFEF00D, 2, 4);
    txn(1'b0, 32'h00000020, 32'h0, 32'h0BADF00D, T - 1, 0);
    txn(1'b1, 32'h00000021, 32'h11223344, 32'h0, T - 1, 1);
    txn(1'b1, 32'h00000022, 32'h55667788, 32'h0, -1, 2);

    // Reset in the middle of a write drops the request.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_index = 32'h00000ABC;
    bus.cmd_data  = 32'h0F0F0F0F;
    check("mid_accept", 64'(bus.cmd_ready), 64'(1));
    tick;
    bus.cmd_valid = 1'b0;
    check("mid_wr_req", 64'(bus.write_req), 64'(1));
    tick;
    check("mid_wr_req2", 64'(bus.write_req), 64'(1));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tc_model = 0;
    check_idle_outs("mid_reset");
    check("mid_tcount", 64'(bus.timeout_count), 64'(0));
    bus.write_ack = 1'b1;
    tick;
    check_idle_outs("stray_ack1");
    tick;
    check_idle_outs("stray_ack2");
    bus.write_ack = 1'b0;

    for (int i = 0; i < 24; i++) begin
      bit wr;
      int ack_at;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ack_at = -1;
      else ack_at = int'($urandom_range(0, T + 2));
      txn(wr, $urandom, $urandom, $urandom, ack_at,
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
